// File: rtl/tx_arb_if.sv
// Bus bundle between the frame requesters, the tx_frame_arbiter and the UART TX FIFO write port.
// The master side is the requesters plus FIFO status; the slave side is the arbiter.
interface tx_arb_if #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 7,
    parameter int LEN_WIDTH   = 7
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
    logic [NUM_REQ-1:0]            s_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] s_data;
    logic [NUM_REQ-1:0]            s_last;
    logic [NUM_REQ-1:0]            s_ready;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic                          err_len;
    logic                          err_timeout;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          fifo_full;
    logic [COUNT_WIDTH-1:0]        fifo_count;

    modport master (
        output req, req_len, s_valid, s_data, s_last, fifo_full, fifo_count,
        input  s_ready, gnt, done, err_len, err_timeout, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        input  req, req_len, s_valid, s_data, s_last, fifo_full, fifo_count,
        output s_ready, gnt, done, err_len, err_timeout, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/tx_frame_arbiter.sv
// Whole-frame round-robin arbiter in front of the shared UART TX FIFO write port.
// Define ARB_STATS_EN to add per-source frame counters and a timeout-abort counter.
module tx_frame_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 64,
    parameter int COUNT_WIDTH    = 7,
    parameter int LEN_WIDTH      = 7,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic    clk,
    input  logic    rst,
    tx_arb_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] frame_cnt,
    output logic [15:0]           abort_cnt
`endif
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d, rr_q, rr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d, done_q, done_d;
    logic                  err_len_q, err_len_d, err_to_q, err_to_d;
    logic [NUM_REQ-1:0]    s_ready_c;
    logic                  wr_en_c;
    logic [DATA_WIDTH-1:0] wr_data_c;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + IDX_W'(1);
    endfunction

    always_comb begin
        logic [COUNT_WIDTH-1:0] free;
        logic [LEN_WIDTH-1:0]   cand_len;
        logic                   found, acc, last_c, reach_c;
        int                     src, g;
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        rr_d       = rr_q;
        byte_cnt_d = byte_cnt_q;
        to_cnt_d   = to_cnt_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        err_len_d  = 1'b0;
        err_to_d   = 1'b0;
        s_ready_c  = '0;
        wr_en_c    = 1'b0;
        wr_data_c  = '0;
        free       = COUNT_WIDTH'(FIFO_DEPTH) - bus.fifo_count;
        cand_len   = '0;
        found      = 1'b0;
        acc        = 1'b0;
        last_c     = 1'b0;
        reach_c    = 1'b0;
        src        = 0;
        g          = int'(idx_q);

        if (state_q == ST_IDLE) begin
            // Requesters with a legal length but no room are passed over without moving rr.
            for (int k = 0; k < NUM_REQ; k++) begin
                src      = (int'(rr_q) + k) % NUM_REQ;
                cand_len = bus.req_len[src*LEN_WIDTH +: LEN_WIDTH];
                if (!found && bus.req[src]) begin
                    if (cand_len == '0 || 32'(cand_len) > 32'(FIFO_DEPTH)) begin
                        found       = 1'b1;
                        done_d[src] = 1'b1;
                        err_len_d   = 1'b1;
                        rr_d        = next_idx(IDX_W'(src));
                    end else if (32'(cand_len) <= 32'(free)) begin
                        found      = 1'b1;
                        idx_d      = IDX_W'(src);
                        len_d      = cand_len;
                        gnt_d      = '0;
                        gnt_d[src] = 1'b1;
                        byte_cnt_d = '0;
                        to_cnt_d   = '0;
                        state_d    = ST_XFER;
                    end
                end
            end
        end else begin
            s_ready_c[g] = !bus.fifo_full;
            acc          = bus.s_valid[g] && !bus.fifo_full;
            wr_en_c      = acc;
            wr_data_c    = bus.s_data[g*DATA_WIDTH +: DATA_WIDTH];
            last_c       = bus.s_last[g];
            reach_c      = (byte_cnt_q + LEN_WIDTH'(1)) == len_q;
            if (acc) begin
                byte_cnt_d = byte_cnt_q + LEN_WIDTH'(1);
                to_cnt_d   = '0;
                if (last_c || reach_c) begin
                    err_len_d = last_c ^ reach_c;
                    done_d[g] = 1'b1;
                end
            end else if (!bus.s_valid[g]) begin
                // Only an idle source ages the timeout; a full FIFO holds the count.
                if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_to_d  = 1'b1;
                    done_d[g] = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            if (done_d[g]) begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                rr_d    = next_idx(idx_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rr_q       <= '0;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_len_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rr_q       <= rr_d;
            byte_cnt_q <= byte_cnt_d;
            to_cnt_q   <= to_cnt_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_len_q  <= err_len_d;
            err_to_q   <= err_to_d;
        end
    end

    always_ff @(posedge clk) begin
        len_q <= len_d;
    end

    assign bus.gnt          = gnt_q;
    assign bus.done         = done_q;
    assign bus.err_len      = err_len_q;
    assign bus.err_timeout  = err_to_q;
    assign bus.s_ready      = s_ready_c;
    assign bus.fifo_wr_en   = wr_en_c;
    assign bus.fifo_wr_data = wr_data_c;

`ifdef ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [NUM_REQ-1:0][15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0]              abort_cnt_q, abort_cnt_d;

    // Only granted frames count; illegal-length rejections never got a grant.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        abort_cnt_d = abort_cnt_q;
        if (state_q == ST_XFER && done_d[idx_q])
            frame_cnt_d[idx_q] = sat_inc(frame_cnt_q[idx_q]);
        if (err_to_d)
            abort_cnt_d = sat_inc(abort_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign abort_cnt = abort_cnt_q;
`endif
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Self-checking bench for tx_frame_arbiter: arbitration vector table, scoreboarded FIFO writes,
// and directed multi-cycle sequences (back-to-back, space wait, mismatch, timeout, illegal len, reset).
module tb_tx_frame_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   wr_count;
    logic [7:0] sb[$];

    tx_arb_if #(.NUM_REQ(2), .DATA_WIDTH(8), .COUNT_WIDTH(7), .LEN_WIDTH(7)) bus();

`ifdef ARB_STATS_EN
    logic [31:0] frame_cnt;
    logic [15:0] abort_cnt;
`endif

    tx_frame_arbiter #(
        .NUM_REQ(2), .DATA_WIDTH(8), .FIFO_DEPTH(64),
        .COUNT_WIDTH(7), .LEN_WIDTH(7), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ARB_STATS_EN
        ,
        .frame_cnt(frame_cnt),
        .abort_cnt(abort_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] req;
        logic [6:0] len0;
        logic [6:0] len1;
        logic [6:0] cnt;
        logic [1:0] gnt;
        logic [1:0] done;
        logic       err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Writes are compared in the low clock phase, before the edge that commits them.
    always @(negedge clk) begin
        if (bus.fifo_wr_en === 1'b1) begin
            wr_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected actual=%0h required=none", bus.fifo_wr_data);
            end else begin
                chk("wr_data", {24'd0, bus.fifo_wr_data}, {24'd0, sb.pop_front()});
            end
        end
    end

    task automatic do_reset();
        bus.req        = '0;
        bus.req_len    = '0;
        bus.s_valid    = '0;
        bus.s_data     = '0;
        bus.s_last     = '0;
        bus.fifo_full  = 1'b0;
        bus.fifo_count = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        wr_count = 0;
    endtask

    task automatic set_len(input int src, input logic [6:0] len);
        bus.req_len[src*7 +: 7] = len;
    endtask

    task automatic send_bytes(input int src, input int n, input int last_at);
        logic [7:0] b;
        for (int i = 1; i <= n; i++) begin
            b = 8'($urandom);
            bus.s_valid[src]        = 1'b1;
            bus.s_data[src*8 +: 8]  = b;
            bus.s_last[src]         = (i == last_at);
            sb.push_back(b);
            @(posedge clk);
            #1;
        end
        bus.s_valid[src] = 1'b0;
        bus.s_last[src]  = 1'b0;
    endtask

    task automatic end_chk(input string name, input int src, input logic err);
        chk({name, "_done"}, {30'd0, bus.done}, 32'(1 << src));
        chk({name, "_gnt_drop"}, {30'd0, bus.gnt}, 32'd0);
        chk({name, "_err_len"}, {31'd0, bus.err_len}, {31'd0, err});
        bus.req[src] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        wr_count = 0;
        rst = 1'b1;
        vecs[0]  = '{2'b11, 7'd4,   7'd4, 7'd0,  2'b01, 2'b00, 1'b0};
        vecs[1]  = '{2'b10, 7'd4,   7'd4, 7'd0,  2'b10, 2'b00, 1'b0};
        vecs[2]  = '{2'b01, 7'd4,   7'd0, 7'd62, 2'b00, 2'b00, 1'b0};
        vecs[3]  = '{2'b11, 7'd4,   7'd2, 7'd62, 2'b10, 2'b00, 1'b0};
        vecs[4]  = '{2'b01, 7'd0,   7'd0, 7'd0,  2'b00, 2'b01, 1'b1};
        vecs[5]  = '{2'b01, 7'd65,  7'd0, 7'd0,  2'b00, 2'b01, 1'b1};
        vecs[6]  = '{2'b01, 7'd64,  7'd0, 7'd0,  2'b01, 2'b00, 1'b0};
        vecs[7]  = '{2'b01, 7'd64,  7'd0, 7'd1,  2'b00, 2'b00, 1'b0};
        vecs[8]  = '{2'b00, 7'd4,   7'd4, 7'd0,  2'b00, 2'b00, 1'b0};
        vecs[9]  = '{2'b11, 7'd0,   7'd3, 7'd0,  2'b00, 2'b01, 1'b1};
        vecs[10] = '{2'b11, 7'd5,   7'd4, 7'd60, 2'b10, 2'b00, 1'b0};
        vecs[11] = '{2'b10, 7'd127, 7'd0, 7'd0,  2'b00, 2'b10, 1'b1};

        do_reset();
        chk("rst_gnt", {30'd0, bus.gnt}, 32'd0);
        chk("rst_done", {30'd0, bus.done}, 32'd0);
        chk("rst_flags", {28'd0, bus.err_len, bus.err_timeout, bus.fifo_wr_en, |bus.s_ready}, 32'd0);
        chk("rst_wr_data", {24'd0, bus.fifo_wr_data}, 32'd0);

        for (int v = 0; v < 12; v++) begin
            do_reset();
            bus.req = vecs[v].req;
            set_len(0, vecs[v].len0);
            set_len(1, vecs[v].len1);
            bus.fifo_count = vecs[v].cnt;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_gnt", v), {30'd0, bus.gnt}, {30'd0, vecs[v].gnt});
            chk($sformatf("vec%0d_done", v), {30'd0, bus.done}, {30'd0, vecs[v].done});
            chk($sformatf("vec%0d_err_len", v), {31'd0, bus.err_len}, {31'd0, vecs[v].err});
            chk($sformatf("vec%0d_s_ready", v), {30'd0, bus.s_ready}, {30'd0, vecs[v].gnt});
        end

        // Two len-4 frames back to back with a one-cycle gap.
        do_reset();
        bus.req = 2'b11;
        set_len(0, 7'd4);
        set_len(1, 7'd4);
        @(posedge clk); #1;
        chk("b2b_gnt0", {30'd0, bus.gnt}, 32'd1);
        send_bytes(0, 4, 4);
        end_chk("b2b_src0", 0, 1'b0);
        @(posedge clk); #1;
        chk("b2b_gnt1", {30'd0, bus.gnt}, 32'd2);
        chk("b2b_done_clear", {30'd0, bus.done}, 32'd0);
        send_bytes(1, 4, 4);
        end_chk("b2b_src1", 1, 1'b0);
        chk("b2b_writes", wr_count, 32'd8);

        // Wait for FIFO space; check full-stall gating once granted.
        do_reset();
        bus.fifo_count = 7'd62;
        bus.req = 2'b01;
        set_len(0, 7'd4);
        repeat (3) @(posedge clk);
        #1;
        chk("space_wait62", {30'd0, bus.gnt}, 32'd0);
        bus.fifo_count = 7'd61;
        @(posedge clk); #1;
        chk("space_wait61", {30'd0, bus.gnt}, 32'd0);
        bus.fifo_count = 7'd60;
        @(posedge clk); #1;
        chk("space_gnt", {30'd0, bus.gnt}, 32'd1);
        bus.fifo_full = 1'b1;
        bus.s_valid[0] = 1'b1;
        #1;
        chk("full_s_ready", {30'd0, bus.s_ready}, 32'd0);
        chk("full_wr_en", {31'd0, bus.fifo_wr_en}, 32'd0);
        bus.s_valid[0] = 1'b0;
        bus.fifo_full = 1'b0;
        @(posedge clk); #1;
        send_bytes(0, 4, 4);
        end_chk("space", 0, 1'b0);
        chk("space_writes", wr_count, 32'd4);

        // Early s_last: length mismatch, rr returns to source 0.
        do_reset();
        bus.req = 2'b10;
        set_len(1, 7'd3);
        @(posedge clk); #1;
        chk("mis_gnt1", {30'd0, bus.gnt}, 32'd2);
        send_bytes(1, 2, 2);
        end_chk("mis", 1, 1'b1);
        chk("mis_writes", wr_count, 32'd2);
        bus.req = 2'b11;
        set_len(0, 7'd2);
        set_len(1, 7'd2);
        @(posedge clk); #1;
        chk("mis_rr0", {30'd0, bus.gnt}, 32'd1);
        send_bytes(0, 2, 2);
        end_chk("mis_next", 0, 1'b0);

        // Timeout after one byte; source 1 gets the next grant.
        do_reset();
        bus.req = 2'b11;
        set_len(0, 7'd4);
        set_len(1, 7'd2);
        @(posedge clk); #1;
        chk("to_gnt0", {30'd0, bus.gnt}, 32'd1);
        send_bytes(0, 1, 0);
        repeat (1023) @(posedge clk);
        #1;
        chk("to_not_yet", {30'd0, bus.gnt, bus.err_timeout}, 32'b010);
        @(posedge clk); #1;
        chk("to_err", {31'd0, bus.err_timeout}, 32'd1);
        end_chk("to", 0, 1'b0);
        chk("to_writes", wr_count, 32'd1);
        @(posedge clk); #1;
        chk("to_gnt1", {30'd0, bus.gnt}, 32'd2);
        send_bytes(1, 2, 2);
        end_chk("to_src1", 1, 1'b0);

        // Illegal length on source 0, then pending source 1 is served.
        do_reset();
        bus.req = 2'b11;
        set_len(0, 7'd0);
        set_len(1, 7'd2);
        @(posedge clk); #1;
        chk("ill_gnt", {30'd0, bus.gnt}, 32'd0);
        end_chk("ill", 0, 1'b1);
        @(posedge clk); #1;
        chk("ill_gnt1", {30'd0, bus.gnt}, 32'd2);
        send_bytes(1, 2, 2);
        end_chk("ill_src1", 1, 1'b0);
        chk("ill_writes", wr_count, 32'd2);

        // Reset mid-frame.
        do_reset();
        bus.req = 2'b01;
        set_len(0, 7'd5);
        set_len(1, 7'd2);
        @(posedge clk); #1;
        chk("rmid_gnt0", {30'd0, bus.gnt}, 32'd1);
        send_bytes(0, 2, 0);
        bus.req = 2'b11;
        set_len(0, 7'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rmid_gnt", {30'd0, bus.gnt}, 32'd0);
        chk("rmid_done", {30'd0, bus.done}, 32'd0);
        chk("rmid_flags", {29'd0, bus.err_len, bus.err_timeout, bus.fifo_wr_en}, 32'd0);
`ifdef ARB_STATS_EN
        chk("rmid_frame_cnt", frame_cnt, 32'd0);
`endif
        @(posedge clk); #1;
        chk("rmid_fresh_gnt0", {30'd0, bus.gnt}, 32'd1);
        send_bytes(0, 2, 2);
        end_chk("rmid_src0", 0, 1'b0);
        chk("rmid_writes", wr_count, 32'd4);
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
